// File: rtl/memory_access.sv
// V850 memory stage: data-bus loads/stores over a req/ack handshake, load lane select and extension.
// Optional bus timeout is built only when MEM_BUS_TIMEOUT_EN is defined.
module memory_access #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    output logic        stall_o,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] result2_i,
    input  logic [4:0]  destination2_i,
    input  logic [4:0]  destination_i,
    input  logic [31:0] PSW_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic [31:0] result_o,
    output logic [31:0] result2_o,
    output logic [4:0]  destination_o,
    output logic [4:0]  destination2_o,
    output logic [31:0] PSW_o,
    output logic        misalign_o,
    output logic        bus_error_o
);

    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDBU = 4'd2;
    localparam logic [3:0] OP_LDH  = 4'd3;
    localparam logic [3:0] OP_LDHU = 4'd4;
    localparam logic [3:0] OP_LDW  = 4'd5;
    localparam logic [3:0] OP_STB  = 4'd6;
    localparam logic [3:0] OP_STH  = 4'd7;
    localparam logic [3:0] OP_STW  = 4'd8;

    typedef enum logic {IDLE, BUS} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  dest_q;
    logic [4:0]  dest2_q;
    logic [31:0] result2_q;
    logic [31:0] psw_q;

    logic        is_mem;
    logic        is_store;
    logic        misaligned;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] lane_word;
    logic [31:0] load_data;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_count;
`else
    // Constant 0 for every legal TIMEOUT_CYCLES; the limit only matters when the timeout is built.
    assign bus_error_o = (TIMEOUT_CYCLES == 32'd0);
`endif

    assign stall_o = (state == BUS);

    always_comb begin
        is_mem     = 1'b0;
        misaligned = 1'b0;
        be         = 4'b0000;
        wdata      = '0;
        case (mem_op_i)
            OP_LDB, OP_LDBU, OP_STB: begin
                is_mem = 1'b1;
                be     = 4'b0001 << result_i[1:0];
                wdata  = {4{store_data_i[7:0]}};
            end
            OP_LDH, OP_LDHU, OP_STH: begin
                is_mem     = 1'b1;
                misaligned = result_i[0];
                be         = result_i[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data_i[15:0]}};
            end
            OP_LDW, OP_STW: begin
                is_mem     = 1'b1;
                misaligned = |result_i[1:0];
                be         = 4'b1111;
                wdata      = store_data_i;
            end
            default: ;
        endcase
        is_store = (mem_op_i == OP_STB) || (mem_op_i == OP_STH) || (mem_op_i == OP_STW);
    end

    // Shift the addressed lane down to bit 0, then extend; words are always lane 0.
    always_comb begin
        lane_word = dbus_rdata_i >> {lane_q, 3'b000};
        case (op_q)
            OP_LDB:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            OP_LDBU: load_data = {24'b0, lane_word[7:0]};
            OP_LDH:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            OP_LDHU: load_data = {16'b0, lane_word[15:0]};
            OP_LDW:  load_data = lane_word;
            default: load_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_q           <= '0;
            lane_q         <= '0;
            dest_q         <= '0;
            dest2_q        <= '0;
            result2_q      <= '0;
            psw_q          <= '0;
            dbus_req_o     <= 1'b0;
            dbus_we_o      <= 1'b0;
            dbus_addr_o    <= '0;
            dbus_be_o      <= '0;
            dbus_wdata_o   <= '0;
            result_o       <= '0;
            result2_o      <= '0;
            destination_o  <= '0;
            destination2_o <= '0;
            PSW_o          <= '0;
            misalign_o     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            wait_count     <= '0;
            bus_error_o    <= 1'b0;
`endif
        end else begin
            misalign_o     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            bus_error_o    <= 1'b0;
`endif
            // Bubble unless something completes below; PSW_o keeps its last value.
            result_o       <= '0;
            result2_o      <= '0;
            destination_o  <= '0;
            destination2_o <= '0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (!is_mem) begin
                            result_o       <= result_i;
                            result2_o      <= result2_i;
                            destination_o  <= destination_i;
                            destination2_o <= destination2_i;
                            PSW_o          <= PSW_i;
                        end else if (misaligned) begin
                            misalign_o <= 1'b1;
                        end else begin
                            op_q         <= mem_op_i;
                            lane_q       <= result_i[1:0];
                            dest_q       <= destination_i;
                            dest2_q      <= destination2_i;
                            result2_q    <= result2_i;
                            psw_q        <= PSW_i;
                            dbus_req_o   <= 1'b1;
                            dbus_we_o    <= is_store;
                            dbus_addr_o  <= {result_i[31:2], 2'b00};
                            dbus_be_o    <= be;
                            dbus_wdata_o <= wdata;
`ifdef MEM_BUS_TIMEOUT_EN
                            wait_count   <= '0;
`endif
                            state        <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (dbus_ack_i) begin
                        result_o       <= load_data;
                        result2_o      <= result2_q;
                        destination_o  <= dbus_we_o ? 5'd0 : dest_q;
                        destination2_o <= dest2_q;
                        PSW_o          <= psw_q;
                        dbus_req_o     <= 1'b0;
                        dbus_we_o      <= 1'b0;
                        state          <= IDLE;
                    end
`ifdef MEM_BUS_TIMEOUT_EN
                    else if (wait_count == TIMEOUT_LAST) begin
                        bus_error_o <= 1'b1;
                        dbus_req_o  <= 1'b0;
                        dbus_we_o   <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a cycle-indexed expectation model checked every cycle, plus literal checks.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        stall_o;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] result_i = '0;
    logic [31:0] store_data_i = '0;
    logic [31:0] result2_i = '0;
    logic [4:0]  destination2_i = '0;
    logic [4:0]  destination_i = '0;
    logic [31:0] PSW_i = '0;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic        dbus_ack_i = 1'b0;
    logic [31:0] dbus_rdata_i = 32'h5A5A_1234;
    logic [31:0] result_o;
    logic [31:0] result2_o;
    logic [4:0]  destination_o;
    logic [4:0]  destination2_o;
    logic [31:0] PSW_o;
    logic        misalign_o;
    logic        bus_error_o;

    memory_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .stall_o(stall_o),
        .mem_op_i(mem_op_i), .result_i(result_i), .store_data_i(store_data_i),
        .result2_i(result2_i), .destination2_i(destination2_i), .destination_i(destination_i),
        .PSW_i(PSW_i), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i), .result_o(result_o),
        .result2_o(result2_o), .destination_o(destination_o), .destination2_o(destination2_o),
        .PSW_o(PSW_o), .misalign_o(misalign_o), .bus_error_o(bus_error_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] res2;
        logic [4:0]  dst;
        logic [4:0]  dst2;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    // Expectations keyed by the clock edge after which they must be visible.
    wb_t         exp_wb[int];
    logic [31:0] exp_psw[int];
    bus_t        exp_bus[int];
    bit          exp_mis[int];
    bit          exp_err[int];
    logic [31:0] psw_model = '0;

    logic        seen_req;
    logic        seen_mis;
    logic [31:0] seen_addr;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;
    logic [4:0]  seen_dst;
    int          stall_cycles;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sizeOf(input logic [3:0] op);
        if (op == 1 || op == 2 || op == 6) return 1;
        if (op == 3 || op == 4 || op == 7) return 2;
        if (op == 5 || op == 8) return 4;
        return 0;
    endfunction

    function automatic bit isStoreOp(input logic [3:0] op);
        return (op >= 6 && op <= 8);
    endfunction

    function automatic bit isMisaligned(input logic [3:0] op, input logic [31:0] addr);
        return (addr % sizeOf(op)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [3:0] op, input logic [31:0] addr);
        case (sizeOf(op))
            1: return 4'(1 << (addr % 4));
            2: return 4'(3 << (addr % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [3:0] op, input logic [31:0] data);
        case (sizeOf(op))
            1: return (data & 32'hFF) * 32'h0101_0101;
            2: return (data & 32'hFFFF) * 32'h0001_0001;
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [3:0] op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = rdata >> ((addr % 4) * 8);
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (op)
            1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            2: return b;
            3: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4: return h;
            5: return rdata;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        wb_t  w;
        bus_t b;
        bit   req;
        if (checking) begin
            w = exp_wb.exists(cyc) ? exp_wb[cyc] : '0;
            if (exp_psw.exists(cyc)) psw_model = exp_psw[cyc];
            req = exp_bus.exists(cyc);
            checkOutput("result", result_o, w.res);
            checkOutput("result2", result2_o, w.res2);
            checkOutput("dest", {27'b0, destination_o}, {27'b0, w.dst});
            checkOutput("dest2", {27'b0, destination2_o}, {27'b0, w.dst2});
            checkOutput("psw", PSW_o, psw_model);
            checkOutput("stall", {31'b0, stall_o}, {31'b0, req});
            checkOutput("req", {31'b0, dbus_req_o}, {31'b0, req});
            checkOutput("misalign", {31'b0, misalign_o}, {31'b0, exp_mis.exists(cyc)});
            checkOutput("bus_error", {31'b0, bus_error_o}, {31'b0, exp_err.exists(cyc)});
            if (req) begin
                b = exp_bus[cyc];
                checkOutput("addr", dbus_addr_o, b.addr);
                checkOutput("be", {28'b0, dbus_be_o}, {28'b0, b.be});
                checkOutput("we", {31'b0, dbus_we_o}, {31'b0, b.we});
                if (b.we) checkOutput("wdata", dbus_wdata_o, b.wdata);
            end
        end
    end

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sdata,
                                 input logic [31:0] res2, input logic [4:0] dst, input logic [4:0] dst2,
                                 input logic [31:0] psw, input logic [31:0] rdata, input int waits);
        int e;
        int a;
        bit go_bus;
        e = cyc + 1;
        go_bus = 1'b0;
        stall_cycles = 0;
        if (sizeOf(op) == 0) begin
            exp_wb[e] = '{res, res2, dst, dst2};
            exp_psw[e] = psw;
        end else if (isMisaligned(op, res)) begin
            exp_mis[e] = 1'b1;
        end else begin
            go_bus = 1'b1;
            for (int k = 0; k <= waits; k++)
                exp_bus[e + k] = '{isStoreOp(op), res & 32'hFFFF_FFFC, modelBe(op, res), modelWdata(op, sdata)};
            a = e + waits + 1;
            exp_wb[a] = '{isStoreOp(op) ? 32'h0 : modelLoad(op, res, rdata), res2,
                          isStoreOp(op) ? 5'd0 : dst, dst2};
            exp_psw[a] = psw;
        end
        mem_op_i = op; result_i = res; store_data_i = sdata; result2_i = res2;
        destination_i = dst; destination2_i = dst2; PSW_i = psw; valid_i = 1'b1;
        waitEdge();
        valid_i = 1'b0;
        mem_op_i = 4'd0;
        seen_req = dbus_req_o; seen_mis = misalign_o; seen_addr = dbus_addr_o;
        seen_be = dbus_be_o; seen_wdata = dbus_wdata_o; seen_dst = destination_o;
        if (go_bus) begin
            for (int k = 0; k <= waits; k++) begin
                if (stall_o) stall_cycles++;
                if (k < waits) waitEdge();
            end
            dbus_ack_i = 1'b1;
            dbus_rdata_i = rdata;
            waitEdge();
            dbus_ack_i = 1'b0;
            dbus_rdata_i = $urandom;
        end
    endtask

`ifdef MEM_BUS_TIMEOUT_EN
    task automatic timeoutStimulus();
        int e;
        int req_cycles;
        e = cyc + 1;
        req_cycles = 0;
        for (int k = 0; k < 4; k++)
            exp_bus[e + k] = '{1'b0, 32'h0000_0900, 4'hF, 32'h0};
        exp_err[e + 4] = 1'b1;
        mem_op_i = 4'd5; result_i = 32'h0000_0900; destination_i = 5'd14;
        destination2_i = 5'd0; result2_i = 32'h0; PSW_i = 32'h77; valid_i = 1'b1;
        waitEdge();
        valid_i = 1'b0;
        mem_op_i = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (dbus_req_o) req_cycles++;
            if (k < 3) waitEdge();
        end
        waitEdge();
        checkOutput("lit_timeout_req_cycles", 32'(req_cycles), 32'd4);
        checkOutput("lit_timeout_error", {31'b0, bus_error_o}, 32'd1);
        checkOutput("lit_timeout_req_low", {31'b0, dbus_req_o}, 32'd0);
        checkOutput("lit_timeout_idle", {31'b0, stall_o}, 32'd0);
    endtask
`endif

    task automatic resetMidBus();
        int e;
        e = cyc + 1;
        exp_bus[e] = '{1'b0, 32'h0000_0300, 4'hF, 32'h0};
        exp_bus[e + 1] = '{1'b0, 32'h0000_0300, 4'hF, 32'h0};
        mem_op_i = 4'd5; result_i = 32'h0000_0300; destination_i = 5'd9; PSW_i = 32'h99; valid_i = 1'b1;
        waitEdge();
        valid_i = 1'b0;
        mem_op_i = 4'd0;
        waitEdge();
        #2;
        checking = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("lit_rst_req_drop", {31'b0, dbus_req_o}, 32'd0);
        checkOutput("lit_rst_stall_drop", {31'b0, stall_o}, 32'd0);
        checkOutput("lit_rst_psw", PSW_o, 32'd0);
        exp_wb.delete(); exp_psw.delete(); exp_bus.delete(); exp_mis.delete(); exp_err.delete();
        psw_model = '0;
        waitEdge();
        waitEdge();
        rst_n = 1'b1;
        waitEdge();
        checking = 1'b1;
    endtask

    initial begin
        #3;
        checkOutput("lit_reset_result", result_o, 32'd0);
        checkOutput("lit_reset_dest", {27'b0, destination_o}, 32'd0);
        checkOutput("lit_reset_psw", PSW_o, 32'd0);
        checkOutput("lit_reset_req", {31'b0, dbus_req_o}, 32'd0);
        checkOutput("lit_reset_stall", {31'b0, stall_o}, 32'd0);
        checkOutput("lit_reset_addr", dbus_addr_o, 32'd0);
        checkOutput("lit_reset_misalign", {31'b0, misalign_o}, 32'd0);
        checkOutput("lit_reset_bus_error", {31'b0, bus_error_o}, 32'd0);
        waitEdge();
        rst_n = 1'b1;
        waitEdge();
        checking = 1'b1;

        applyStimulus(4'd0, 32'h0000_1234, 32'h0, 32'h55, 5'd5, 5'd7, 32'h20, 32'h0, 0);
        checkOutput("lit_alu_result", result_o, 32'h0000_1234);
        checkOutput("lit_alu_dest", {27'b0, destination_o}, 32'd5);
        checkOutput("lit_alu_stall", {31'b0, stall_o}, 32'd0);

        applyStimulus(4'd9, 32'hCAFE_F00D, 32'h0, 32'h66, 5'd3, 5'd4, 32'h21, 32'h0, 0);
        checkOutput("lit_op9_result", result_o, 32'hCAFE_F00D);

        applyStimulus(4'd1, 32'h0000_0103, 32'h0, 32'h11, 5'd10, 5'd2, 32'h40, 32'h80FF_FF7F, 3);
        checkOutput("lit_ldb_addr", seen_addr, 32'h0000_0100);
        checkOutput("lit_ldb_be", {28'b0, seen_be}, 32'h8);
        checkOutput("lit_ldb_stall_cycles", 32'(stall_cycles), 32'd4);
        checkOutput("lit_ldb_result", result_o, 32'hFFFF_FF80);
        checkOutput("lit_ldb_dest", {27'b0, destination_o}, 32'd10);

        applyStimulus(4'd4, 32'h0000_0202, 32'h0, 32'h22, 5'd11, 5'd0, 32'h41, 32'hBEEF_0000, 0);
        checkOutput("lit_ldhu_result", result_o, 32'h0000_BEEF);
        checkOutput("lit_ldhu_stall", {31'b0, stall_o}, 32'd0);

        applyStimulus(4'd7, 32'h0000_0011, 32'h0000_00AB, 32'h33, 5'd12, 5'd1, 32'h42, 32'h0, 0);
        checkOutput("lit_sth_mis_pulse", {31'b0, seen_mis}, 32'd1);
        checkOutput("lit_sth_mis_noreq", {31'b0, seen_req}, 32'd0);
        checkOutput("lit_sth_mis_dest", {27'b0, seen_dst}, 32'd0);

        applyStimulus(4'd6, 32'h0000_0011, 32'h0000_00AB, 32'h44, 5'd13, 5'd6, 32'h43, 32'h0, 1);
        checkOutput("lit_stb_be", {28'b0, seen_be}, 32'h2);
        checkOutput("lit_stb_wdata", seen_wdata, 32'hABAB_ABAB);
        checkOutput("lit_stb_dest", {27'b0, destination_o}, 32'd0);

        applyStimulus(4'd8, 32'h0000_0400, 32'h1234_5678, 32'h0, 5'd15, 5'd0, 32'h44, 32'h0, 0);
        applyStimulus(4'd3, 32'h0000_0502, 32'h0, 32'h0, 5'd16, 5'd0, 32'h45, 32'h8001_7FFF, 2);
        checkOutput("lit_ldh_result", result_o, 32'hFFFF_8001);
        applyStimulus(4'd2, 32'h0000_0601, 32'h0, 32'h0, 5'd17, 5'd0, 32'h46, 32'h0000_9A00, 0);
        checkOutput("lit_ldbu_result", result_o, 32'h0000_009A);
        applyStimulus(4'd5, 32'h0000_0700, 32'h0, 32'h0, 5'd18, 5'd0, 32'h47, 32'hA5A5_0F0F, 1);
        applyStimulus(4'd5, 32'h0000_0702, 32'h0, 32'h0, 5'd19, 5'd0, 32'h48, 32'h0, 0);
        applyStimulus(4'd7, 32'h0000_0802, 32'h1234_BEEF, 32'h0, 5'd20, 5'd0, 32'h49, 32'h0, 0);
        checkOutput("lit_sth_wdata", seen_wdata, 32'hBEEF_BEEF);

        dbus_ack_i = 1'b1;
        dbus_rdata_i = 32'hDEAD_BEEF;
        waitEdge();
        dbus_ack_i = 1'b0;
        checkOutput("lit_idle_ack_ignored", result_o, 32'd0);

`ifdef MEM_BUS_TIMEOUT_EN
        timeoutStimulus();
        applyStimulus(4'd5, 32'h0000_0A00, 32'h0, 32'h0, 5'd21, 5'd0, 32'h4A, 32'h0BAD_F00D, 3);
        checkOutput("lit_ack_at_limit_result", result_o, 32'h0BAD_F00D);
        checkOutput("lit_ack_at_limit_noerror", {31'b0, bus_error_o}, 32'd0);
`endif

        resetMidBus();
        applyStimulus(4'd0, 32'h0000_4321, 32'h0, 32'h0, 5'd8, 5'd0, 32'h50, 32'h0, 0);
        checkOutput("lit_post_reset_alu", result_o, 32'h0000_4321);

        repeat (3) waitEdge();
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline stage between execute and the writeback stage of the V850 core. It takes the execute result, performs data-bus loads and stores with a req/ack handshake and wait states, and aligns and extends load data. It then presents registered results, destinations and PSW to writeback. Non-memory instructions pass through with one cycle of latency. Memory instructions stall the upstream pipeline until the bus completes.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: bus wait limit. Used only when MEM_BUS_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_i  in  1  execute presents an instruction
- stall_o  out  1  stage busy; upstream holds its inputs
- mem_op_i  in  4  0 none, 1 LD.B, 2 LD.BU, 3 LD.H, 4 LD.HU, 5 LD.W, 6 ST.B, 7 ST.H, 8 ST.W; 9-15 treated as none
- result_i  in  32  ALU result; effective address when mem_op_i is 1-8
- store_data_i  in  32  store source register value
- result2_i, destination2_i  in  32, 5  second write port, passed through
- destination_i  in  5  load/ALU destination register
- PSW_i  in  32  PSW after execute
- dbus_req_o, dbus_we_o  out  1, 1  bus request, write enable
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_be_o  out  4  byte enables, little-endian
- dbus_wdata_o  out  32  store data, lane-replicated
- dbus_ack_i  in  1  transfer complete this cycle
- dbus_rdata_i  in  32  read data, valid with ack
- result_o, result2_o  out  32, 32  to writeback
- destination_o, destination2_o  out  5, 5  to writeback
- PSW_o  out  32  to writeback
- misalign_o  out  1  one-cycle misaligned-access pulse
- bus_error_o  out  1  one-cycle bus timeout pulse

## Operation
- Accept when valid_i & ~stall_o. stall_o = (state == BUS), combinational.
- Bubble: result_o, result2_o, destination_o, destination2_o = 0, which writes 0 to r0 and is harmless. PSW_o holds its value. A bubble is driven whenever no result completes in a cycle.
- Non-memory op: result*, destination*, PSW_i are registered to the outputs.
- Memory op, aligned: the stage latches address, op, store data, destinations, result2 and PSW, then goes to BUS.
- Alignment rule: H requires addr[0]=0; W requires addr[1:0]=0. A misaligned access produces no bus cycle, asserts misalign_o for one cycle, drives a bubble and stays in IDLE.
- FSM states:
  - IDLE: an aligned memory op moves to BUS.
  - BUS: dbus_req_o=1, with address, be and wdata held stable. On dbus_ack_i, capture the result and go to IDLE.
- Store byte enables: B uses 1<<addr[1:0]; H uses 4'b0011 or 4'b1100; W uses 4'b1111. wdata replicates byte ×4 or halfword ×2.
- Load data: select the lane by addr[1:0]. LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend.
- A completed load writes the extended data to destination_o. A completed store drives destination_o=0. result2 and destination2 are delivered on completion in both cases.
- dbus_ack_i outside BUS is ignored.

## Timing
- Reset: state IDLE, and every output is 0, including dbus_*, stall_o, PSW_o and the pulses. Assertion mid-transfer drops dbus_req_o asynchronously, and the instruction is lost.
- Non-memory op accepted at cycle T: outputs are valid at T+1.
- Memory op accepted at T: dbus_req_o is high from T+1. With ack at cycle A ≥ T+1, outputs are valid at A+1, and stall_o falls at A+1 so a new op can be accepted at A+1.
- Zero-wait (ack at T+1): 2-cycle load-to-writeback latency.
- misalign_o pulses at T+1. bus_error_o pulses in the cycle after the timeout.

## Configuration
- MEM_BUS_TIMEOUT_EN defined: a 16-bit counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES, the stage drops req, pulses bus_error_o, drives a bubble and returns to IDLE. An ack in the same cycle as the limit wins, and the transfer completes normally.
- MEM_BUS_TIMEOUT_EN undefined: BUS waits indefinitely, no counter is built, and bus_error_o is tied 0.

## Test plan
- ALU op: result_i=0x1234, destination_i=5 -> result_o=0x1234, destination_o=5 next cycle; stall_o stays 0.
- LD.B addr 0x103, rdata 0x80FF_FF7F, ack after 3 waits -> dbus_addr_o=0x100, be=4'b1000, stall_o high 4 cycles, result_o=0xFFFF_FF80.
- LD.HU addr 0x202, rdata 0xBEEF_0000, zero-wait -> result_o=0x0000_BEEF two cycles after accept.
- ST.H addr 0x11 -> no dbus_req_o, misalign_o 1 cycle, destination_o=0. ST.B addr 0x11, data 0xAB -> be=4'b0010, wdata=0xABAB_ABAB.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req high 4 cycles, bus_error_o pulse, return to IDLE. Repeat with ack on the 4th cycle -> normal completion, no error.
- rst_n low mid-BUS -> dbus_req_o=0 immediately; after release, an ALU op completes normally.
